// File: rtl/noc_axi4_bridge_write.sv
// ============================================================================
// Module   : noc_axi4_bridge_write
// Brief    : Write-side NoC-to-AXI4 bridge, one outstanding burst at a time.
// Revision : 1.0
// ============================================================================
`default_nettype none

`ifndef AXI4_DATA_WIDTH
`define AXI4_DATA_WIDTH 512
`endif
`ifndef AXI4_ADDR_WIDTH
`define AXI4_ADDR_WIDTH 64
`endif
`ifndef AXI4_ID_WIDTH
`define AXI4_ID_WIDTH 4
`endif
`ifndef AXI4_USER_WIDTH
`define AXI4_USER_WIDTH 1
`endif
`ifndef MSG_DATA_SIZE_WIDTH
`define MSG_DATA_SIZE_WIDTH 3
`endif

module noc_axi4_bridge_write #(
    parameter int AXI4_DAT_WIDTH_USED = `AXI4_DATA_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 req_val,
    input  logic [`AXI4_ADDR_WIDTH-1:0]          req_addr,
    input  logic [`MSG_DATA_SIZE_WIDTH-1:0]      req_size_log,
    input  logic [`AXI4_ID_WIDTH-1:0]            req_id,
    input  logic [`AXI4_DATA_WIDTH-1:0]          req_data,
    output logic                                 req_rdy,
    output logic                                 resp_val,
    output logic [`AXI4_ID_WIDTH-1:0]            resp_id,
    output logic                                 resp_err,
    input  logic                                 resp_rdy,
    output logic [`AXI4_ID_WIDTH-1:0]            m_axi_awid,
    output logic [`AXI4_ADDR_WIDTH-1:0]          m_axi_awaddr,
    output logic [7:0]                           m_axi_awlen,
    output logic [2:0]                           m_axi_awsize,
    output logic [1:0]                           m_axi_awburst,
    output logic                                 m_axi_awlock,
    output logic [3:0]                           m_axi_awcache,
    output logic [2:0]                           m_axi_awprot,
    output logic [3:0]                           m_axi_awqos,
    output logic [3:0]                           m_axi_awregion,
    output logic [`AXI4_USER_WIDTH-1:0]          m_axi_awuser,
    output logic                                 m_axi_awvalid,
    input  logic                                 m_axi_awready,
    output logic [AXI4_DAT_WIDTH_USED-1:0]       m_axi_wdata,
    output logic [AXI4_DAT_WIDTH_USED/8-1:0]     m_axi_wstrb,
    output logic                                 m_axi_wlast,
    output logic [`AXI4_USER_WIDTH-1:0]          m_axi_wuser,
    output logic                                 m_axi_wvalid,
    input  logic                                 m_axi_wready,
    input  logic [`AXI4_ID_WIDTH-1:0]            m_axi_bid,
    input  logic [1:0]                           m_axi_bresp,
    input  logic                                 m_axi_bvalid,
    output logic                                 m_axi_bready
);

    localparam int W    = AXI4_DAT_WIDTH_USED;
    localparam int SB   = W / 8;
    localparam int LB   = $clog2(SB);
    localparam int MAXB = `AXI4_DATA_WIDTH / W;
    localparam int SW   = (MAXB > 1) ? $clog2(MAXB) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_BUSY   = 2'd1,
        S_WAIT_B = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                              state_q;
    logic [`AXI4_ADDR_WIDTH-1:0]         addr_q;
    logic [`MSG_DATA_SIZE_WIDTH-1:0]     size_q;
    logic [`AXI4_ID_WIDTH-1:0]           id_q;
    logic [`AXI4_DATA_WIDTH-1:0]         data_q;
    logic [7:0]                          beat_q;
    logic                                aw_done_q;
    logic                                w_done_q;
    logic                                req_rdy_q;
    logic                                awvalid_q;
    logic                                wvalid_q;
    logic                                bready_q;
    logic                                resp_val_q;
    logic                                resp_err_q;

    logic signed [4:0]                   w_bl;
    logic                                w_full;
    logic [7:0]                          w_awlen;
    logic [2:0]                          w_awsize;
    logic [SB-1:0]                       w_strb;
    logic                                w_last;
    logic [W-1:0]                        w_lanes [MAXB];
    logic                                w_unused;

    // Burst shape from the captured size: full-width beats when the request
    // is at least one bus word, otherwise a single narrow transfer.
    assign w_bl     = 5'(size_q) - 5'(LB);
    assign w_full   = ~w_bl[4];
    assign w_awlen  = w_full ? ((8'd1 << w_bl[2:0]) - 8'd1) : 8'd0;
    assign w_awsize = w_full ? 3'(LB) : size_q[2:0];
    assign w_last   = wvalid_q && (beat_q == w_awlen);

    for (genvar g = 0; g < MAXB; g++) begin : g_lane
        assign w_lanes[g] = data_q[g*W +: W];
    end

    // Beat slice wraps within the 64-byte line starting at the address lane.
    if (MAXB > 1) begin : g_multi
        logic [SW-1:0] w_slice;
        assign w_slice     = addr_q[5:LB] + beat_q[SW-1:0];
        assign m_axi_wdata = w_lanes[w_slice];
    end else begin : g_single
        assign m_axi_wdata = w_lanes[0];
    end

    if (LB > 0) begin : g_narrow
        logic [LB-1:0] w_off;
        assign w_off = addr_q[LB-1:0];
        always_comb begin
            w_strb = '1;
            if (!w_full) begin
                for (int i = 0; i < SB; i++) begin
                    w_strb[i] = (i >= int'(w_off)) && (i < int'(w_off) + (1 << size_q));
                end
            end
        end
    end else begin : g_wide
        assign w_strb = '1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            size_q     <= '0;
            id_q       <= '0;
            data_q     <= '0;
            beat_q     <= '0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            req_rdy_q  <= 1'b1;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            resp_val_q <= 1'b0;
            resp_err_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_val) begin
                        addr_q    <= req_addr;
                        size_q    <= req_size_log;
                        id_q      <= req_id;
                        data_q    <= req_data;
                        beat_q    <= '0;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        req_rdy_q <= 1'b0;
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        state_q   <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (awvalid_q && m_axi_awready) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (wvalid_q && m_axi_wready) begin
                        beat_q <= beat_q + 8'd1;
                        if (w_last) begin
                            wvalid_q <= 1'b0;
                            w_done_q <= 1'b1;
                        end
                    end
                    if (aw_done_q && w_done_q) begin
                        bready_q <= 1'b1;
                        state_q  <= S_WAIT_B;
                    end
                end
                S_WAIT_B: begin
                    if (m_axi_bvalid) begin
                        bready_q   <= 1'b0;
                        resp_err_q <= m_axi_bresp[1];
                        resp_val_q <= 1'b1;
                        state_q    <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (resp_rdy) begin
                        resp_val_q <= 1'b0;
                        req_rdy_q  <= 1'b1;
                        state_q    <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_rdy        = req_rdy_q;
    assign resp_val       = resp_val_q;
    assign resp_id        = id_q;
    assign resp_err       = resp_err_q;
    assign m_axi_awid     = id_q;
    assign m_axi_awaddr   = addr_q;
    assign m_axi_awlen    = w_awlen;
    assign m_axi_awsize   = w_awsize;
    assign m_axi_awburst  = 2'b01;
    assign m_axi_awlock   = 1'b0;
    assign m_axi_awcache  = 4'b0011;
    assign m_axi_awprot   = 3'b000;
    assign m_axi_awqos    = 4'b0000;
    assign m_axi_awregion = 4'b0000;
    assign m_axi_awuser   = '0;
    assign m_axi_awvalid  = awvalid_q;
    assign m_axi_wstrb    = w_strb;
    assign m_axi_wlast    = w_last;
    assign m_axi_wuser    = '0;
    assign m_axi_wvalid   = wvalid_q;
    assign m_axi_bready   = bready_q;

    // Single outstanding write: B ordering is implicit, so bid carries nothing.
    assign w_unused = ^{m_axi_bid, m_axi_bresp[0]};

endmodule

`default_nettype wire
